boot_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of the single-cycle core's instruction memory. It holds the core in reset, receives a framed program image over a byte handshake (fed by the UART receiver), assembles little-endian 32-bit instructions, and writes them into instruction memory word by word. It releases the core's reset only after a complete, verified image has been written.

---
 rtl/boot_loader.sv | 159 +++++++++++++++
 tb/tb_boot_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Framed byte-stream loader: holds the core in reset and writes the image into imem.
// Define BOOT_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module boot_loader #(
    parameter int MEM_WORDS = 152,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_FLUSH,
        S_RUN,
        S_ERROR
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t S_POST = S_CSUM;
`else
    localparam state_t S_POST = S_FLUSH;
`endif

    localparam logic [7:0] SYNC = 8'hA5;

    state_t state;
    state_t state_d;

    logic [15:0]       len;
    logic [15:0]       len_n;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic              take;
    logic              last_word;
    logic              enter_len0;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign take       = rx_valid && rx_ready;
    assign len_n      = {rx_data, len[7:0]};
    assign last_word  = (16'(word_idx) == len - 16'd1);
    assign enter_len0 = (state_d == S_LEN0) && (state != S_LEN0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (take && rx_data == SYNC) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (take) state_d = S_LEN1;
            end
            S_LEN1: begin
                if (take) begin
                    if (len_n > 16'(MEM_WORDS)) state_d = S_ERROR;
                    else if (len_n == 16'd0)    state_d = S_POST;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (take && byte_cnt == 2'd3 && last_word) state_d = S_POST;
            end
            S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
                if (take) state_d = (rx_data == csum) ? S_FLUSH : S_ERROR;
`else
                state_d = S_ERROR;
`endif
            end
            S_FLUSH: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_ERROR: begin
                if (take && rx_data == SYNC) state_d = S_LEN0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_ready  <= !(state_d == S_FLUSH || state_d == S_RUN);
            cpu_reset <= (state_d != S_RUN);
            done      <= (state_d == S_RUN);
            error     <= (state_d == S_ERROR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (enter_len0) begin
                word_idx <= '0;
                byte_cnt <= '0;
            end
            if (take && state == S_LEN0) len[7:0]  <= rx_data;
            if (take && state == S_LEN1) len[15:8] <= rx_data;
            if (take && state == S_DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_q    <= {rx_data, asm_q[23:8]};
                if (byte_cnt == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_idx;
                    imem_wdata <= {rx_data, asm_q};
                    word_idx   <= word_idx + ADDR_W'(1);
                end
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (enter_len0) begin
            csum <= '0;
        end else if (take && state == S_DATA) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed/randomized bench for boot_loader with a frame-level reference model.
module tb_boot_loader;

    localparam int MEM_WORDS = 152;
    localparam int ADDR_W    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int stalls = 0;

    logic [31:0] words[$];
    logic [7:0]  frame[$];
    logic [39:0] wq[$];

    always @(negedge clk) begin
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic rr,
                                input logic cr, input logic dn,
                                input logic er);
        check({tag, ".rx_ready"}, 32'(rx_ready), 32'(rr));
        check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cr));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".error"}, 32'(error), 32'(er));
    endtask

    // Called and returns at a falling edge; the byte is accepted in between.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (n >= 100) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic make_frame(input logic [7:0] corrupt);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] n;
        frame.delete();
        cs = 8'h00;
        n  = 16'(words.size());
        frame.push_back(8'hA5);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b  = 8'(words[i] >> (8 * k));
                cs = cs ^ b;
                frame.push_back(b);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        frame.push_back(cs ^ corrupt);
`else
        if (corrupt != 8'h00) frame.push_back(cs);
`endif
    endtask

    task automatic send_frame(input int maxgap);
        foreach (frame[i]) send_byte(frame[i], $urandom_range(0, maxgap));
    endtask

    task automatic check_writes(input string tag);
        check({tag, ".nwrites"}, 32'(wq.size()), 32'(words.size()));
        foreach (wq[i]) begin
            if (i < words.size()) begin
                check({tag, ".addr"}, 32'(wq[i][39:32]), 32'(i));
                check({tag, ".data"}, wq[i][31:0], words[i]);
            end
        end
    endtask

    task automatic check_boot(input string tag);
        check_status({tag, ".flush"}, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_status({tag, ".run"}, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check({tag, ".stall"}, 32'(rx_ready), 32'd0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wq.delete();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset.imem_we", 32'(imem_we), 32'd0);
        reset = 1'b0;
        #1 check("release.rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check_status("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        words = '{32'h00100513, 32'h00200593};
        make_frame(8'h00);
        stalls = 0;
        send_frame(0);
        check("b2b.stalls", 32'(stalls), 32'd0);
        check_boot("two_word");
        check_writes("two_word");

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        make_frame(8'h01);
        send_frame(0);
        check_status("bad_csum", 1'b1, 1'b1, 1'b0, 1'b1);
        check_writes("bad_csum");
        wq.delete();
        make_frame(8'h00);
        send_byte(frame[0], 0);
        check("retry.error_clear", 32'(error), 32'd0);
        for (int i = 1; i < frame.size(); i++) send_byte(frame[i], 0);
        check_boot("retry");
        check_writes("retry");
`endif

        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'(MEM_WORDS + 1), 0);
        send_byte(8'h00, 0);
        check_status("oversize", 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("oversize.nwrites", 32'(wq.size()), 32'd0);

        do_reset();
        words.delete();
        make_frame(8'h00);
        send_frame(0);
        check_boot("empty");
        check_writes("empty");

        do_reset();
        words = '{32'h00100513, 32'h00200593};
        make_frame(8'h00);
        send_byte(8'h00, $urandom_range(0, 3));
        send_byte(8'hFF, $urandom_range(0, 3));
        send_frame(4);
        check_boot("noise");
        check_writes("noise");

        for (int t = 0; t < 4; t++) begin
            do_reset();
            words.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) words.push_back($urandom);
            make_frame(8'h00);
            send_frame(3);
            check_boot("random");
            check_writes("random");
        end

        do_reset();
        words = '{$urandom, $urandom};
        make_frame(8'h00);
        for (int i = 0; i < 9; i++) send_byte(frame[i], 0);
        reset = 1'b1;
        #1;
        check_status("mid_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_reset.imem_we", 32'(imem_we), 32'd0);
        check("mid_reset.addr", 32'(imem_addr), 32'd0);
        check("mid_reset.wdata", imem_wdata, 32'd0);
        check("mid_reset.nwrites", 32'(wq.size()), 32'd1);
        do_reset();
        words = '{$urandom};
        make_frame(8'h00);
        send_frame(2);
        check_boot("after_reset");
        check_writes("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
